// File: rtl/tod_clock_param_pkg.sv
// Shared definitions for the parametrised time-of-day clock:
// time-unit constants, splitter state encoding and a width helper.
package tod_pkg;

  localparam int SEC_PER_HOUR = 3600;
  localparam int SEC_PER_MIN  = 60;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_HOURS = 2'd1,
    S_MINS  = 2'd2,
    S_DONE  = 2'd3
  } split_state_e;

  // Number of bits needed to hold values 0..value-1 (minimum 1).
  function automatic int clog2(input int value);
    int bits;
    longint span;
    bits = 0;
    span = 64'sd1;
    while (span < longint'(value)) begin
      span = span << 1;
      bits = bits + 1;
    end
    if (bits < 1) begin
      bits = 1;
    end
    return bits;
  endfunction

endpackage

// File: rtl/tod_clock_param_if.sv
// Control / time bus of the time-of-day clock.
// master = controlling logic, slave = tod_clock_param.
// Alarm signals exist only when TOD_ALARM_EN is defined.
interface tod_clock_param_if #(
  parameter int TIME_W = 17
);

  logic              load;
  logic [TIME_W-1:0] load_time;
  logic              pause;
  logic              step;
  logic [TIME_W-1:0] sec_of_day;
  logic [4:0]        hours;
  logic [5:0]        minutes;
  logic [5:0]        seconds;
  logic              hms_valid;
  logic              sec_tick;
  logic              day_wrap;
  logic              load_err;
`ifdef TOD_ALARM_EN
  logic              alarm_set;
  logic [TIME_W-1:0] alarm_time;
  logic              alarm_hit;
`endif

  modport master (
`ifdef TOD_ALARM_EN
    output alarm_set, alarm_time,
    input  alarm_hit,
`endif
    output load, load_time, pause, step,
    input  sec_of_day, hours, minutes, seconds,
    input  hms_valid, sec_tick, day_wrap, load_err
  );

  modport slave (
`ifdef TOD_ALARM_EN
    input  alarm_set, alarm_time,
    output alarm_hit,
`endif
    input  load, load_time, pause, step,
    output sec_of_day, hours, minutes, seconds,
    output hms_valid, sec_tick, day_wrap, load_err
  );

endinterface

// File: rtl/tod_clock_param_hms_split.sv
// Sequential seconds-of-day to hours/minutes/seconds converter.
// Repeated subtraction: one hour per cycle, then one minute per cycle.
// A start strobe in any state restarts the conversion with i_value.
module tod_hms_split
  import tod_pkg::*;
#(
  parameter int TIME_W = 17
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_start,
  input  logic [TIME_W-1:0] i_value,
  output logic              o_busy,
  output logic              o_done,
  output logic [4:0]        o_hours,
  output logic [5:0]        o_minutes,
  output logic [5:0]        o_seconds
);

  localparam logic [TIME_W-1:0] HOUR_W = TIME_W'(SEC_PER_HOUR);
  localparam logic [TIME_W-1:0] MIN_W  = TIME_W'(SEC_PER_MIN);

  split_state_e      r_state;
  split_state_e      w_state_nxt;
  logic [TIME_W-1:0] r_rem;
  logic [4:0]        r_h;
  logic [5:0]        r_m;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: start overrides everything, otherwise walk the phases.
  always_comb begin
    w_state_nxt = r_state;
    if (i_start) begin
      w_state_nxt = S_HOURS;
    end else begin
      case (r_state)
        S_IDLE:  w_state_nxt = S_IDLE;
        S_HOURS: begin
          if (r_rem < HOUR_W) begin
            w_state_nxt = S_MINS;
          end else begin
            w_state_nxt = S_HOURS;
          end
        end
        S_MINS: begin
          if (r_rem < MIN_W) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_MINS;
          end
        end
        S_DONE:  w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Remainder and digit counters, updated by the active phase.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rem <= '0;
      r_h   <= 5'd0;
      r_m   <= 6'd0;
    end else if (i_start) begin
      r_rem <= i_value;
      r_h   <= 5'd0;
      r_m   <= 6'd0;
    end else begin
      case (r_state)
        S_HOURS: begin
          if (r_rem >= HOUR_W) begin
            r_rem <= r_rem - HOUR_W;
            r_h   <= r_h + 5'd1;
          end
        end
        S_MINS: begin
          if (r_rem >= MIN_W) begin
            r_rem <= r_rem - MIN_W;
            r_m   <= r_m + 6'd1;
          end
        end
        default: begin
          r_rem <= r_rem;
        end
      endcase
    end
  end

  assign o_busy    = (r_state != S_IDLE);
  assign o_done    = (r_state == S_DONE);
  assign o_hours   = r_h;
  assign o_minutes = r_m;
  assign o_seconds = r_rem[5:0];

endmodule

// File: rtl/tod_clock_param.sv
// Parametrised time-of-day clock: prescaler, seconds-of-day counter,
// load/pause/step control, tick and day-wrap strobes, and an h/m/s view
// kept in lockstep once the splitter has converted a loaded value.
// Optional alarm comparator enabled by defining TOD_ALARM_EN.
module tod_clock_param
  import tod_pkg::*;
#(
  parameter int CLK_HZ  = 50000000,
  parameter int DAY_SEC = 86400,
  parameter int TIME_W  = 17
) (
  input  logic              clk,
  input  logic              reset,
  tod_clock_param_if.slave  bus
);

  localparam int                PRE_W    = clog2(CLK_HZ);
  localparam logic [PRE_W-1:0]  PRE_TOP  = PRE_W'(CLK_HZ - 1);
  localparam logic [TIME_W-1:0] DAY_LIM  = TIME_W'(DAY_SEC);
  localparam logic [TIME_W-1:0] DAY_LAST = TIME_W'(DAY_SEC - 1);

  logic [PRE_W-1:0]  r_presc;
  logic [TIME_W-1:0] r_sec;
  logic [4:0]        r_hours;
  logic [5:0]        r_minutes;
  logic [5:0]        r_seconds;
  logic              r_valid;
  logic              r_tick;
  logic              r_wrap;
  logic              r_err;
  logic              r_dirty;

  logic              w_load_ok;
  logic              w_load_bad;
  logic              w_adv;
  logic              w_wrap;
  logic [TIME_W-1:0] w_sec_nxt;
  logic              w_restart;
  logic              w_commit;
  logic              w_start;
  logic              w_alarm_bad;

  logic              w_busy;
  logic              w_split_done;
  logic [4:0]        w_sp_h;
  logic [5:0]        w_sp_m;
  logic [5:0]        w_sp_s;

  // Decode load/advance conditions and the next seconds-of-day value.
  always_comb begin
    w_load_ok  = bus.load && (bus.load_time < DAY_LIM);
    w_load_bad = bus.load && !(bus.load_time < DAY_LIM);
    if (bus.load) begin
      w_adv = 1'b0;
    end else if (bus.pause) begin
      w_adv = bus.step;
    end else begin
      w_adv = (r_presc == PRE_TOP);
    end
    w_wrap = w_adv && (r_sec == DAY_LAST);
    if (w_load_ok) begin
      w_sec_nxt = bus.load_time;
    end else if (w_wrap) begin
      w_sec_nxt = '0;
    end else if (w_adv) begin
      w_sec_nxt = r_sec + TIME_W'(1);
    end else begin
      w_sec_nxt = r_sec;
    end
    // A finished conversion is stale if time moved since it started
    // or moves on this very edge; convert again from the new value.
    w_restart = w_split_done && (r_dirty || w_adv) && !w_load_ok;
    w_commit  = w_split_done && !r_dirty && !w_adv && !w_load_ok;
    w_start   = w_load_ok || w_restart;
  end

  tod_hms_split #(
    .TIME_W(TIME_W)
  ) u_split (
    .clk       (clk),
    .reset     (reset),
    .i_start   (w_start),
    .i_value   (w_sec_nxt),
    .o_busy    (w_busy),
    .o_done    (w_split_done),
    .o_hours   (w_sp_h),
    .o_minutes (w_sp_m),
    .o_seconds (w_sp_s)
  );

  // Prescaler: frozen by pause or a rejected load, cleared by load or advance.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_presc <= '0;
    end else if (w_load_bad) begin
      r_presc <= r_presc;
    end else if (w_load_ok) begin
      r_presc <= '0;
    end else if (bus.pause) begin
      r_presc <= r_presc;
    end else if (r_presc == PRE_TOP) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + PRE_W'(1);
    end
  end

  // Seconds-of-day counter and one-cycle strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sec  <= '0;
      r_tick <= 1'b0;
      r_wrap <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_sec  <= w_sec_nxt;
      r_tick <= w_adv;
      r_wrap <= w_wrap;
      r_err  <= w_load_bad || w_alarm_bad;
    end
  end

  // Remember whether time moved while a conversion is in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_dirty <= 1'b0;
    end else if (w_start) begin
      r_dirty <= 1'b0;
    end else if (w_adv && w_busy) begin
      r_dirty <= 1'b1;
    end else begin
      r_dirty <= r_dirty;
    end
  end

  // H/M/S view: invalid during conversion, then counts alongside r_sec.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hours   <= 5'd0;
      r_minutes <= 6'd0;
      r_seconds <= 6'd0;
      r_valid   <= 1'b1;
    end else if (w_load_ok || w_restart) begin
      r_valid   <= 1'b0;
    end else if (w_commit) begin
      r_hours   <= w_sp_h;
      r_minutes <= w_sp_m;
      r_seconds <= w_sp_s;
      r_valid   <= 1'b1;
    end else if (w_adv && r_valid) begin
      if (w_wrap) begin
        r_hours   <= 5'd0;
        r_minutes <= 6'd0;
        r_seconds <= 6'd0;
      end else if (r_seconds != 6'd59) begin
        r_seconds <= r_seconds + 6'd1;
      end else if (r_minutes != 6'd59) begin
        r_seconds <= 6'd0;
        r_minutes <= r_minutes + 6'd1;
      end else begin
        r_seconds <= 6'd0;
        r_minutes <= 6'd0;
        r_hours   <= r_hours + 5'd1;
      end
    end else begin
      r_valid <= r_valid;
    end
  end

`ifdef TOD_ALARM_EN
  logic [TIME_W-1:0] r_alarm;
  logic              r_armed;
  logic              r_hit;
  logic              w_alarm_ok;

  // Alarm set request decode.
  always_comb begin
    w_alarm_ok  = bus.alarm_set && (bus.alarm_time < DAY_LIM);
    w_alarm_bad = bus.alarm_set && !(bus.alarm_time < DAY_LIM);
  end

  // Alarm register, arming and hit strobe on advance or load.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_alarm <= '0;
      r_armed <= 1'b0;
      r_hit   <= 1'b0;
    end else begin
      if (w_alarm_ok) begin
        r_alarm <= bus.alarm_time;
        r_armed <= 1'b1;
      end
      r_hit <= r_armed && (w_load_ok || w_adv) && (w_sec_nxt == r_alarm);
    end
  end

  assign bus.alarm_hit = r_hit;
`else
  assign w_alarm_bad = 1'b0;
`endif

  assign bus.sec_of_day = r_sec;
  assign bus.hours      = r_hours;
  assign bus.minutes    = r_minutes;
  assign bus.seconds    = r_seconds;
  assign bus.hms_valid  = r_valid;
  assign bus.sec_tick   = r_tick;
  assign bus.day_wrap   = r_wrap;
  assign bus.load_err   = r_err;

endmodule

// File: tb/tb_tod_clock_param.sv
// Directed bench for tod_clock_param with CLK_HZ=10.
// Alarm steps are included when TOD_ALARM_EN is defined.
module tb_tod_clock_param;

  localparam int CLK_HZ  = 10;
  localparam int DAY_SEC = 86400;
  localparam int TIME_W  = 17;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;
  int   cyc;
  int   c0;
  int   es;
  int   nt;

  tod_clock_param_if #(.TIME_W(TIME_W)) bus ();

  tod_clock_param #(
    .CLK_HZ (CLK_HZ),
    .DAY_SEC(DAY_SEC),
    .TIME_W (TIME_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_hms(input string tag, input int s);
    chk({tag, "_h"}, 64'(bus.hours),   64'(s / 3600));
    chk({tag, "_m"}, 64'(bus.minutes), 64'((s % 3600) / 60));
    chk({tag, "_s"}, 64'(bus.seconds), 64'(s % 60));
  endtask

  task automatic wait_valid(input string tag, input int bound);
    int k;
    k = 0;
    while (bus.hms_valid !== 1'b1 && k < bound) begin
      tick(1);
      k++;
    end
    chk(tag, 64'(bus.hms_valid), 64'd1);
  endtask

  task automatic do_load(input int v);
    bus.load      = 1'b1;
    bus.load_time = TIME_W'(v);
    tick(1);
    bus.load      = 1'b0;
  endtask

  initial begin
    n_vec = 0; n_err = 0; cyc = 0;
    reset = 1'b1;
    bus.load = 1'b0; bus.load_time = '0; bus.pause = 1'b0; bus.step = 1'b0;
`ifdef TOD_ALARM_EN
    bus.alarm_set = 1'b0; bus.alarm_time = '0;
`endif
    tick(3);
    chk("rst_sec",   64'(bus.sec_of_day), 64'd0);
    chk_hms("rst", 0);
    chk("rst_valid", 64'(bus.hms_valid), 64'd1);
    chk("rst_tick",  64'(bus.sec_tick),  64'd0);
    chk("rst_wrap",  64'(bus.day_wrap),  64'd0);
    chk("rst_err",   64'(bus.load_err),  64'd0);

    // Free run: ticks after edges 10, 20, 30.
    reset = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      tick(1);
      chk("run_tick", 64'(bus.sec_tick), 64'((i % 10) == 0));
    end
    chk("run_sec", 64'(bus.sec_of_day), 64'd3);
    chk_hms("run", 3);

    // Day wrap from 86398, then conversion catches up with the running time.
    do_load(86398);
    c0 = cyc;
    chk("wrap_ld_sec",   64'(bus.sec_of_day), 64'd86398);
    chk("wrap_ld_valid", 64'(bus.hms_valid),  64'd0);
    chk("wrap_ld_tick",  64'(bus.sec_tick),   64'd0);
    for (int i = 1; i <= 20; i++) begin
      tick(1);
      chk("wrap_tick", 64'(bus.sec_tick), 64'((i % 10) == 0));
      chk("wrap_flag", 64'(bus.day_wrap), 64'(i == 20));
      if (i == 10) chk("wrap_sec10", 64'(bus.sec_of_day), 64'd86399);
      if (i == 20) chk("wrap_sec20", 64'(bus.sec_of_day), 64'd0);
    end
    wait_valid("wrap_valid", 150);
    es = (86398 + (cyc - c0) / 10) % DAY_SEC;
    chk("wrap_v_sec", 64'(bus.sec_of_day), 64'(es));
    chk_hms("wrap_v", es);
    tick(15);
    es = (86398 + (cyc - c0) / 10) % DAY_SEC;
    chk("lock_sec", 64'(bus.sec_of_day), 64'(es));
    chk_hms("lock", es);

    // Paused load of 45296, conversion within 84 cycles; rejected load.
    bus.pause = 1'b1;
    do_load(45296);
    chk("cv_valid0", 64'(bus.hms_valid), 64'd0);
    wait_valid("cv_valid", 84);
    chk("cv_sec", 64'(bus.sec_of_day), 64'd45296);
    chk_hms("cv", 45296);
    do_load(86400);
    chk("bad_err",   64'(bus.load_err),   64'd1);
    chk("bad_sec",   64'(bus.sec_of_day), 64'd45296);
    chk("bad_valid", 64'(bus.hms_valid),  64'd1);
    tick(1);
    chk("bad_err_off", 64'(bus.load_err), 64'd0);

    // Prescaler frozen at 4, three steps, then 6 cycles to the next tick.
    bus.pause = 1'b0;
    tick(4);
    bus.pause = 1'b1;
    nt = 0;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      if (bus.sec_tick === 1'b1) nt++;
    end
    chk("pause_ticks", 64'(nt), 64'd0);
    chk("pause_sec", 64'(bus.sec_of_day), 64'd45296);
    for (int j = 0; j < 3; j++) begin
      bus.step = 1'b1;
      tick(1);
      bus.step = 1'b0;
      chk("step_tick", 64'(bus.sec_tick), 64'd1);
      tick(1);
      chk("step_tick_off", 64'(bus.sec_tick), 64'd0);
    end
    chk("step_sec", 64'(bus.sec_of_day), 64'd45299);
    chk_hms("step", 45299);
    bus.pause = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick(1);
      chk("resume_tick", 64'(bus.sec_tick), 64'(i == 6));
    end
    chk("resume_sec", 64'(bus.sec_of_day), 64'd45300);
    chk_hms("resume", 45300);
    bus.step = 1'b1;
    tick(1);
    bus.step = 1'b0;
    chk("nostep_tick", 64'(bus.sec_tick),   64'd0);
    chk("nostep_sec",  64'(bus.sec_of_day), 64'd45300);

    // Advance during conversion forces a restart from the new value.
    bus.pause = 1'b1;
    do_load(3599);
    chk("rs_valid0", 64'(bus.hms_valid), 64'd0);
    tick(3);
    bus.step = 1'b1;
    tick(1);
    bus.step = 1'b0;
    chk("rs_tick",   64'(bus.sec_tick),   64'd1);
    chk("rs_valid1", 64'(bus.hms_valid),  64'd0);
    wait_valid("rs_valid", 200);
    chk("rs_sec", 64'(bus.sec_of_day), 64'd3600);
    chk_hms("rs", 3600);

    // Seconds and minutes carry into hours in lockstep.
    do_load(7199);
    wait_valid("cy_valid", 200);
    chk_hms("cy_pre", 7199);
    bus.step = 1'b1;
    tick(1);
    bus.step = 1'b0;
    chk("cy_sec", 64'(bus.sec_of_day), 64'd7200);
    chk_hms("cy", 7200);

    // Reset during a conversion.
    do_load(45296);
    tick(5);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk("rmid_valid", 64'(bus.hms_valid),  64'd1);
    chk("rmid_sec",   64'(bus.sec_of_day), 64'd0);
    chk_hms("rmid", 0);

`ifdef TOD_ALARM_EN
    bus.alarm_set = 1'b1; bus.alarm_time = TIME_W'(90000);
    tick(1);
    bus.alarm_set = 1'b0;
    chk("al_bad_err", 64'(bus.load_err), 64'd1);
    bus.alarm_set = 1'b1; bus.alarm_time = TIME_W'(5);
    tick(1);
    bus.alarm_set = 1'b0;
    chk("al_set_err", 64'(bus.load_err), 64'd0);
    bus.pause = 1'b0;
    do_load(0);
    chk("al_hit_ld0", 64'(bus.alarm_hit), 64'd0);
    for (int i = 1; i <= 60; i++) begin
      tick(1);
      chk("al_hit", 64'(bus.alarm_hit), 64'(i == 50));
    end
    do_load(5);
    chk("al_hit_ld5", 64'(bus.alarm_hit), 64'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
